// File: rtl/reg_pkg.sv
// Shared register-file constants used by the register bank, Decode and Forwarding.
package reg_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on commit, wiped on flush.
module reg_scoreboard #(
  parameter int unsigned ADDR_W = reg_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] regdest_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [ADDR_W-1:0] addra_i,
  input  logic [ADDR_W-1:0] addrb_i,
  output logic              busya_o,
  output logic              busyb_o
);
  import reg_pkg::*;

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [NumRegs-1:0] pending_q, pending_d;

  // Later assignments override earlier ones: flush > set > clear.
  always_comb begin
    pending_d = pending_q;
    if (wr_en_i) begin
      pending_d[wr_addr_i] = 1'b0;
    end
    if (issue_i && (regdest_i != ZeroAddr)) begin
      pending_d[regdest_i] = 1'b1;
    end
    if (flush_i) begin
      pending_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // A commit in the current cycle releases the operand, matching the read bypass.
  always_comb begin
    busya_o = pending_q[addra_i] && !(wr_en_i && (wr_addr_i == addra_i))
              && (addra_i != ZeroAddr);
    busyb_o = pending_q[addrb_i] && !(wr_en_i && (wr_addr_i == addrb_i))
              && (addrb_i != ZeroAddr);
  end

endmodule

// File: rtl/reg_bank.sv
// General-purpose register bank: two combinational read ports with write-through bypass,
// one commit port, and a pending-write scoreboard for Decode.
module reg_bank #(
  parameter int unsigned DATA_W = reg_pkg::DATA_W,
  parameter int unsigned ADDR_W = reg_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] id_reg_addra,
  input  logic [ADDR_W-1:0] id_reg_addrb,
  output logic [DATA_W-1:0] reg_id_rega,
  output logic [DATA_W-1:0] reg_id_regb,
  input  logic              id_reg_issue,
  input  logic [ADDR_W-1:0] id_reg_regdest,
  output logic              reg_id_busya,
  output logic              reg_id_busyb,
  input  logic              wb_reg_writereg,
  input  logic [ADDR_W-1:0] wb_reg_addr,
  input  logic [DATA_W-1:0] wb_reg_wbvalue,
  input  logic              fw_reg_flush
);
  import reg_pkg::*;

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NumRegs];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_reg_writereg && (wb_reg_addr != ZeroAddr)) begin
      regs_q[wb_reg_addr] <= wb_reg_wbvalue;
    end
  end

  always_comb begin
    reg_id_rega = regs_q[id_reg_addra];
    if (wb_reg_writereg && (wb_reg_addr == id_reg_addra)) begin
      reg_id_rega = wb_reg_wbvalue;
    end
    if (id_reg_addra == ZeroAddr) begin
      reg_id_rega = '0;
    end

    reg_id_regb = regs_q[id_reg_addrb];
    if (wb_reg_writereg && (wb_reg_addr == id_reg_addrb)) begin
      reg_id_regb = wb_reg_wbvalue;
    end
    if (id_reg_addrb == ZeroAddr) begin
      reg_id_regb = '0;
    end
  end

  reg_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .flush_i   (fw_reg_flush),
    .issue_i   (id_reg_issue),
    .regdest_i (id_reg_regdest),
    .wr_en_i   (wb_reg_writereg),
    .wr_addr_i (wb_reg_addr),
    .addra_i   (id_reg_addra),
    .addrb_i   (id_reg_addrb),
    .busya_o   (reg_id_busya),
    .busyb_o   (reg_id_busyb)
  );

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus a randomized phase against a model.
module tb_reg_bank;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_reg_addra, id_reg_addrb, id_reg_regdest, wb_reg_addr;
  logic [31:0] reg_id_rega, reg_id_regb, wb_reg_wbvalue;
  logic        id_reg_issue, reg_id_busya, reg_id_busyb, wb_reg_writereg, fw_reg_flush;

  always #5 clock = ~clock;

  reg_bank dut (
    .clock           (clock),
    .reset           (reset),
    .id_reg_addra    (id_reg_addra),
    .id_reg_addrb    (id_reg_addrb),
    .reg_id_rega     (reg_id_rega),
    .reg_id_regb     (reg_id_regb),
    .id_reg_issue    (id_reg_issue),
    .id_reg_regdest  (id_reg_regdest),
    .reg_id_busya    (reg_id_busya),
    .reg_id_busyb    (reg_id_busyb),
    .wb_reg_writereg (wb_reg_writereg),
    .wb_reg_addr     (wb_reg_addr),
    .wb_reg_wbvalue  (wb_reg_wbvalue),
    .fw_reg_flush    (fw_reg_flush)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rega;
    logic [31:0] regb;
    logic        busya;
    logic        busyb;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_reg_writereg && wb_reg_addr == a) return wb_reg_wbvalue;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    return (a != 5'd0) && m_pend[a] && !(wb_reg_writereg && wb_reg_addr == a);
  endfunction

  task automatic drive(input logic rst, input logic iss, input logic [4:0] dest,
                       input logic wr, input logic [4:0] waddr, input logic [31:0] wval,
                       input logic fl, input logic [4:0] a, input logic [4:0] b);
    reset = rst; id_reg_issue = iss; id_reg_regdest = dest;
    wb_reg_writereg = wr; wb_reg_addr = waddr; wb_reg_wbvalue = wval;
    fw_reg_flush = fl; id_reg_addra = a; id_reg_addrb = b;
  endtask

  // Push the model's prediction for the current inputs, then pop and compare mid-cycle.
  task automatic settle(input string tag);
    exp_t e;
    e.rega = m_read(id_reg_addra);
    e.regb = m_read(id_reg_addrb);
    e.busya = m_busy(id_reg_addra);
    e.busyb = m_busy(id_reg_addrb);
    exp_q.push_back(e);
    #3;
    e = exp_q.pop_front();
    check_eq({tag, ".rega"}, reg_id_rega, e.rega);
    check_eq({tag, ".regb"}, reg_id_regb, e.regb);
    check_eq({tag, ".busya"}, {31'd0, reg_id_busya}, {31'd0, e.busya});
    check_eq({tag, ".busyb"}, {31'd0, reg_id_busyb}, {31'd0, e.busyb});
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pend = 32'd0;
    end else begin
      if (wb_reg_writereg && wb_reg_addr != 5'd0) m_regs[wb_reg_addr] = wb_reg_wbvalue;
      if (wb_reg_writereg) m_pend[wb_reg_addr] = 1'b0;
      if (id_reg_issue && id_reg_regdest != 5'd0) m_pend[id_reg_regdest] = 1'b1;
      if (fw_reg_flush) m_pend = 32'd0;
    end
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    tick();
    tick();

    // Reset state on every register, both ports
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'(i), 5'(31 - i));
      settle("reset_rd");
      check_eq("reset_rega", reg_id_rega, 32'd0);
      check_eq("reset_regb", reg_id_regb, 32'd0);
      check_eq("reset_busy", {30'd0, reg_id_busya, reg_id_busyb}, 32'd0);
      tick();
    end

    // Bypass then storage
    drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
    settle("bypass");
    check_eq("bypass_r5", reg_id_rega, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd5);
    settle("stored");
    check_eq("stored_r5", reg_id_regb, 32'hDEADBEEF);
    tick();

    // Register zero: writes discarded, never pending
    drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0);
    settle("r0_wr");
    check_eq("r0_bypass", reg_id_rega, 32'd0);
    tick();
    drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    settle("r0_busy");
    check_eq("r0_busya", {31'd0, reg_id_busya}, 32'd0);
    tick();

    // Issue r7, then commit releases it in the same cycle
    drive(1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0);
    settle("iss7_same");
    check_eq("iss7_not_yet", {31'd0, reg_id_busya}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0);
    settle("iss7");
    check_eq("r7_busy", {31'd0, reg_id_busya}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 32'd40, 1'b0, 5'd7, 5'd0);
    settle("cmt7");
    check_eq("r7_released", {31'd0, reg_id_busya}, 32'd0);
    check_eq("r7_value", reg_id_rega, 32'd40);
    tick();

    // Set wins over clear on the same register; different registers both act
    drive(1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 32'd3, 1'b0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd0);
    settle("setwins");
    check_eq("r3_busy", {31'd0, reg_id_busya}, 32'd1);
    tick();
    drive(1'b0, 1'b1, 5'd4, 1'b1, 5'd3, 32'd33, 1'b0, 5'd3, 5'd4);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd4);
    settle("setclr");
    check_eq("r3_clear", {31'd0, reg_id_busya}, 32'd0);
    check_eq("r4_set", {31'd0, reg_id_busyb}, 32'd1);
    tick();

    // Flush clears everything and drops the concurrent issue
    drive(1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0, 1'b0, 5'd8, 5'd9);
    tick();
    drive(1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd8, 5'd9);
    tick();
    drive(1'b0, 1'b1, 5'd10, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd9);
    settle("pre_flush");
    check_eq("r9_pend", {31'd0, reg_id_busyb}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd8, 5'd9);
    settle("flush89");
    check_eq("flush_r8_r9", {30'd0, reg_id_busya, reg_id_busyb}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd10, 5'd4);
    settle("flush10");
    check_eq("flush_r10_r4", {30'd0, reg_id_busya, reg_id_busyb}, 32'd0);
    tick();

    // Reset overrides a concurrent commit and discards ownership
    drive(1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0, 1'b0, 5'd8, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 32'd20, 1'b0, 5'd8, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd8, 5'd5);
    settle("post_reset");
    check_eq("rst_r8_val", reg_id_rega, 32'd0);
    check_eq("rst_r8_busy", {31'd0, reg_id_busya}, 32'd0);
    check_eq("rst_r5_val", reg_id_regb, 32'd0);
    tick();

    // Randomized traffic; small address range for frequent collisions
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 19) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      settle("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
